// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the SPI/host RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 24;

    localparam int REQ_SPI  = 0;
    localparam int REQ_HOST = 1;

endpackage

// File: rtl/spi_ram_arb_pick.sv
// Two-way grant picker; round-robin when SPI_RAM_ARB_RR_EN is defined, else req0 priority.
// Latency: combinational.
// Backpressure: none; the grant is one-hot, or zero when nothing is valid.
module spi_ram_arb_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef SPI_RAM_ARB_RR_EN
    // On contention the requester that did not win last time goes next.
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = {valid1, valid0};
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = {valid1 && !valid0, valid0};
`endif

endmodule

// File: rtl/spi_ram_arbiter.sv
// Single-port RAM arbiter between SPI engine (req0) and host (req1); SPI_RAM_ARB_RR_EN selects round-robin.
// Latency: write response at T+2, read response at T+3 after accept; one IDLE cycle between accesses.
// Backpressure: reqN_ready is high only in IDLE for the granted requester; losers hold valid.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    arb_state_t            state, state_nxt;
    logic [1:0]            grant;
    logic                  last_grant;
    logic                  accept;
    logic                  sel_owner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  owner_q;
    logic                  we_q;
    logic                  cs_nxt, we_nxt, oe_nxt;
    logic [1:0]            rsp_vld_nxt;

    spi_ram_arb_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef SPI_RAM_ARB_RR_EN
    // Reset value 1 lets req0 win the first contention.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= sel_owner;
        end
    end
`else
    assign last_grant = 1'b1;
`endif

    assign req0_ready = rstn && (state == IDLE) && grant[REQ_SPI];
    assign req1_ready = rstn && (state == IDLE) && grant[REQ_HOST];
    assign accept     = rstn && (state == IDLE) && (grant != 2'b00);
    assign busy       = (state != IDLE);

    assign sel_owner = grant[REQ_HOST];
    assign sel_we    = sel_owner ? req1_we    : req0_we;
    assign sel_addr  = sel_owner ? req1_addr  : req0_addr;
    assign sel_wdata = sel_owner ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = we_q ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM controls are registered, so they are decoded from the state being entered.
    always_comb begin
        cs_nxt      = 1'b0;
        we_nxt      = 1'b0;
        oe_nxt      = 1'b0;
        rsp_vld_nxt = 2'b00;
        case (state_nxt)
            ACCESS: begin
                cs_nxt = 1'b1;
                we_nxt = sel_we;
                oe_nxt = !sel_we;
            end
            CAPTURE: begin
                cs_nxt = 1'b1;
                oe_nxt = 1'b1;
            end
            RESP:    rsp_vld_nxt[owner_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_oe     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            ram_cs     <= cs_nxt;
            ram_we     <= we_nxt;
            ram_oe     <= oe_nxt;
            rsp0_valid <= rsp_vld_nxt[0];
            rsp1_valid <= rsp_vld_nxt[1];
            if (accept) begin
                owner_q   <= sel_owner;
                we_q      <= sel_we;
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
            end
            if (state == CAPTURE) begin
                if (owner_q) begin
                    rsp1_rdata <= ram_rdata;
                end else begin
                    rsp0_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a synchronous RAM model.
// Covers reset, table-driven accesses, contention and reset mid-read.
module tb_spi_ram_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_ready, req0_we;
    logic [4:0]  req0_addr;
    logic [23:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [4:0]  req1_addr;
    logic [23:0] req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [23:0] rsp0_rdata, rsp1_rdata;
    logic        ram_cs, ram_we, ram_oe;
    logic [4:0]  ram_addr;
    logic [23:0] ram_wdata, ram_rdata;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    // RAM model: write or latch on a cs edge, drive latched data while oe.
    logic [23:0] mem [32];
    logic [23:0] tmp_data;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) mem[i] <= 24'h0;
            mem[0]   <= 24'hFEDCBA;
            mem[5]   <= 24'hA5A5A5;
            tmp_data <= 24'h0;
        end else if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        tmp_data      <= mem[ram_addr];
        end
    end
    assign ram_rdata = ram_oe ? tmp_data : 24'h0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int r, input logic v, input logic w,
                             input logic [4:0] a, input logic [23:0] d);
        if (r == 0) begin
            req0_valid = v; req0_we = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    function automatic logic rdy_of(input int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic vld_of(input int r);
        return (r == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [23:0] rdata_of(input int r);
        return (r == 0) ? rsp0_rdata : rsp1_rdata;
    endfunction

    // One access by a lone requester; lat counts cycles after the accept cycle.
    task automatic xact(input int r, input logic w, input logic [4:0] a, input logic [23:0] d,
                        output int lat, output int cs_cyc, output int stray, output logic [23:0] rd);
        bit got_rdy;
        lat = 0; cs_cyc = 0; stray = 0; rd = 24'h0; got_rdy = 0;
        @(negedge clk);
        drive_req(r, 1'b1, w, a, d);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rdy_of(r)) begin
                got_rdy = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 drive_req(r, 1'b0, w, a, d);
        if (got_rdy) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (ram_cs) cs_cyc++;
                if (vld_of(1 - r)) stray++;
                if (vld_of(r)) begin
                    lat = k;
                    rd  = rdata_of(r);
                    break;
                end
            end
        end
    endtask

    typedef struct {
        int          req;
        logic        we;
        logic [4:0]  addr;
        logic [23:0] wdata;
        logic [23:0] exp_rdata;
    } vec_t;

    vec_t        vecs [8];
    int          lat, cs_cyc, stray, seen, nrsp, viol, derr, n1;
    logic [23:0] rd;
    logic [23:0] model [2];
    int          owners [8];
    int          times [8];

    initial begin
        vecs[0] = '{1, 1'b1, 5'd31, 24'h123456, 24'h0};
        vecs[1] = '{1, 1'b0, 5'd31, 24'h0,      24'h123456};
        vecs[2] = '{0, 1'b0, 5'd5,  24'h0,      24'hA5A5A5};
        vecs[3] = '{0, 1'b1, 5'd7,  24'hABCDEF, 24'h0};
        vecs[4] = '{1, 1'b0, 5'd7,  24'h0,      24'hABCDEF};
        vecs[5] = '{0, 1'b0, 5'd31, 24'h0,      24'h123456};
        vecs[6] = '{1, 1'b1, 5'd0,  24'h000000, 24'h0};
        vecs[7] = '{0, 1'b0, 5'd0,  24'h0,      24'h000000};

        rstn = 1'b0;
        drive_req(0, 1'b0, 1'b0, 5'd0, 24'h0);
        drive_req(1, 1'b0, 1'b0, 5'd0, 24'h0);

        // Reset state; ready must stay low during reset even with valid high.
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1 chk("ready0_in_reset", {31'h0, req0_ready}, 32'h0);
        req0_valid = 1'b0;
        @(negedge clk) rstn = 1'b1;
        #1;
        chk("rst_ram_cs", {31'h0, ram_cs}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_ram_oe", {31'h0, ram_oe}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rsp_valid", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
        chk("rst_rsp0_rdata", {8'h0, rsp0_rdata}, 32'h0);
        chk("rst_rsp1_rdata", {8'h0, rsp1_rdata}, 32'h0);

        // First read after reset.
        xact(0, 1'b0, 5'd0, 24'h0, lat, cs_cyc, stray, rd);
        chk("rst_read_lat", lat, 3);
        chk("rst_read_cs", cs_cyc, 2);
        chk("rst_read_data", {8'h0, rd}, 32'h00FEDCBA);

        // Reset asserted during CAPTURE of a req1 read.
        @(negedge clk);
        drive_req(1, 1'b1, 1'b0, 5'd5, 24'h0);
        #1 chk("midrd_ready1", {31'h0, req1_ready}, 32'h1);
        @(posedge clk);
        #1 drive_req(1, 1'b0, 1'b0, 5'd5, 24'h0);
        @(negedge clk);
        @(negedge clk);
        chk("midrd_cs_capture", {30'h0, ram_cs, ram_oe}, 32'h3);
        rstn = 1'b0;
        #1;
        chk("midrd_cs_async", {31'h0, ram_cs}, 32'h0);
        chk("midrd_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen++;
        end
        chk("midrd_no_rsp", seen, 0);
        chk("midrd_rsp0_rdata", {8'h0, rsp0_rdata}, 32'h0);
        chk("midrd_rsp1_rdata", {8'h0, rsp1_rdata}, 32'h0);

        // Contention: both requesters read addr 0 continuously.
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 5'd0, 24'h0);
        drive_req(1, 1'b1, 1'b0, 5'd0, 24'h0);
        nrsp = 0; viol = 0; derr = 0; n1 = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            #1;
            if (req0_valid && req1_ready) viol++;
            if (rsp0_valid || rsp1_valid) begin
                if (rsp1_valid) n1++;
                if (nrsp < 8) begin
                    owners[nrsp] = rsp1_valid ? 1 : 0;
                    times[nrsp]  = cyc;
                end
                if (rdata_of(rsp1_valid ? 1 : 0) !== 24'hFEDCBA) derr++;
                nrsp++;
            end
            if (cyc == 40) begin
                drive_req(0, 1'b0, 1'b0, 5'd0, 24'h0);
                drive_req(1, 1'b0, 1'b0, 5'd0, 24'h0);
            end
        end
        chk("cont_enough_rsp", {31'h0, nrsp >= 4}, 32'h1);
        chk("cont_data", derr, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef SPI_RAM_ARB_RR_EN
            chk($sformatf("cont_owner%0d", i), owners[i], i % 2);
`else
            chk($sformatf("cont_owner%0d", i), owners[i], 0);
`endif
            if (i > 0) chk($sformatf("cont_gap%0d", i), times[i] - times[i-1], 4);
        end
`ifdef SPI_RAM_ARB_RR_EN
        model[0] = 24'hFEDCBA;
        model[1] = 24'hFEDCBA;
`else
        chk("cont_ready1_blocked", viol, 0);
        chk("cont_no_rsp1", n1, 0);
        model[0] = 24'hFEDCBA;
        model[1] = 24'h0;
`endif

        // Table-driven single-requester accesses.
        for (int i = 0; i < 8; i++) begin
            xact(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, cs_cyc, stray, rd);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].we ? 2 : 3);
            chk($sformatf("v%0d_cs_cycles", i), cs_cyc, vecs[i].we ? 1 : 2);
            chk($sformatf("v%0d_other_rsp", i), stray, 0);
            if (!vecs[i].we) model[vecs[i].req] = vecs[i].exp_rdata;
            chk($sformatf("v%0d_own_rdata", i), {8'h0, rd}, {8'h0, model[vecs[i].req]});
            chk($sformatf("v%0d_other_rdata", i), {8'h0, rdata_of(1 - vecs[i].req)},
                {8'h0, model[1 - vecs[i].req]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Arbitrates the single-port synchronous 24-bit × 32 RAM between two requesters: requester 0 is the SPI slave engine (frame load/write-back), requester 1 is the local host/config port. It sequences every RAM access through cs/we/oe, captures read data, and returns a per-requester response. It sits between both requesters and the RAM instance; top-level glue maps `ram_wdata`/`ram_rdata` onto the RAM's inout data bus.

## Interface
- `ADDR_WIDTH`, 5: RAM address width.
- `DATA_WIDTH`, 24: RAM data width.

Ports:
- `clk` in 1: the single clock for the block and the RAM.
- `rstn` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: access request.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when asserted together with `valid`.
- `req0_we`, `req1_we` in 1: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in ADDR_WIDTH: RAM address.
- `req0_wdata`, `req1_wdata` in DATA_WIDTH: write data.
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle completion pulse for both reads and writes.
- `rsp0_rdata`, `rsp1_rdata` out DATA_WIDTH: read data; holds its value until that requester's next read response.
- `ram_cs`, `ram_we`, `ram_oe` out 1: RAM controls.
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_wdata` out DATA_WIDTH: RAM write data.
- `ram_rdata` in DATA_WIDTH: RAM read data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - `reqN_ready` is combinational. It is high only for the granted requester, and only in IDLE.
  - On `valid && ready`, the arbiter registers owner, we, addr and wdata, then goes to ACCESS.
- ACCESS:
  - Drives `ram_cs=1`, `ram_we=we`, `ram_oe=!we`, plus addr and wdata.
  - A write goes to RESP. A read goes to CAPTURE.
- CAPTURE (reads only):
  - Holds `ram_cs=1`, `ram_oe=1`, `ram_we=0`.
  - Registers `ram_rdata` into the owner's `rspN_rdata`.
  - Goes to RESP.
- RESP:
  - All `ram_*` controls are 0.
  - `rspN_valid=1` for the owner only, for exactly one cycle.
  - Goes to IDLE.
- Grant rule:
  - Only one requester valid: that requester is granted.
  - Both valid: see Configuration.
  - The grant is evaluated only in IDLE and never changes mid-access.
- Requester rule: once `valid` is raised, the requester holds `valid`/`we`/`addr`/`wdata` stable until `ready`. Dropping `valid` early is a protocol violation; the arbiter need not detect it.
- No address checking: all 32 addresses 0..31 are legal. Address arithmetic is the requester's job.
- Outputs are registered, except `reqN_ready` and `busy`.

## Timing
- Accept at the edge ending cycle T.
- Write:
  - ACCESS in T+1; the RAM writes at the edge ending T+1.
  - `rsp_valid` in T+2.
  - Next accept is possible in T+3, so one write per 3 cycles.
- Read:
  - ACCESS in T+1; the RAM latches `tmp_data` at the edge ending T+1.
  - `ram_rdata` is valid in T+2 (CAPTURE).
  - `rsp_valid` and new `rsp_rdata` appear in T+3.
  - Next accept is possible in T+4, so one read per 4 cycles.
- A requester that keeps `valid` high through RESP is re-arbitrated in the following IDLE cycle. There are no back-to-back accepts without an IDLE cycle.
- Reset values:
  - All `ram_*` = 0; `reqN_ready` = 0 (combinational ready is forced low while `!rstn`); `rsp*_valid` = 0; `rsp*_rdata` = 0; `busy` = 0.
  - State = IDLE; last-grant register = 1.
- Reset asserted mid-access: the state returns to IDLE immediately and `ram_cs` drops asynchronously. An in-flight write completes only if its RAM edge has already occurred. No response is issued for an aborted access.

## Configuration
- `SPI_RAM_ARB_RR_EN` defined:
  - Round-robin. On contention the requester other than `last_grant` wins.
  - `last_grant` updates on every accept. The reset value of 1 makes req0 win the first contention.
- Not defined:
  - Fixed priority: req0 (SPI) always wins contention.
  - The last-grant register is not present.

## Structure
- Shared package `spi_ram_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ACCESS, CAPTURE, RESP};
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants;
  - requester-index localparams `REQ_SPI=0`, `REQ_HOST=1`.
- One sub-module, `spi_ram_arb_pick`: a combinational two-way grant picker taking both valids and `last_grant`, producing a one-hot grant. It holds the `SPI_RAM_ARB_RR_EN` conditional logic.

## Test plan
- Reset: after `rstn` deasserts, `ram_cs/we/oe`=0, `busy`=0, both `rsp_valid`=0; a req0 read of addr 0 → `rsp0_rdata`=24'hFEDCBA at T+3.
- Write then read: req1 writes 24'h123456 to addr 31 → `rsp1_valid` at T+2; req1 then reads addr 31 → `rsp1_rdata`=24'h123456, with `ram_cs` high for exactly 2 cycles.
- Contention with `SPI_RAM_ARB_RR_EN`: both requesters continuously issue reads of addr 0 → grants alternate req0, req1, req0, req1; each response arrives 4 cycles apart.
- Contention without the macro: the same stimulus → req0 is granted every time; `req1_ready` never asserts while req0 stays valid.
- Reset mid-read: assert `rstn` low during CAPTURE → `ram_cs` drops immediately; no `rsp_valid`; `rsp_rdata` reads 0 after reset.
- Response isolation: req0 reads addr 5 (holding 24'hA5A5A5) while req1 is idle → only `rsp0_valid` pulses; `rsp1_rdata` is unchanged.
